// File: rtl/lorenz_attractor.sv
// Fixed-point Lorenz oscillator: forward-Euler integration in Q11.21, one new
// (x,y,z) sample every two clocks while start_i is high.
module lorenz_attractor #(
  parameter int Width = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  output logic signed [Width-1:0] xn_o,
  output logic signed [Width-1:0] yn_o,
  output logic signed [Width-1:0] zn_o
);

  localparam int FRAC = 21;

  localparam logic signed [Width-1:0] ONE = Width'(32'sh0020_0000);
  localparam logic signed [Width-1:0] HS  = Width'(32'sd20972);
  localparam logic signed [Width-1:0] H   = Width'(32'sd2097);
  localparam logic signed [Width-1:0] HB  = Width'(32'sd5592);
  localparam logic signed [Width-1:0] RHO = Width'(32'sh0380_0000);

  typedef enum logic {
    CALC   = 1'b0,
    UPDATE = 1'b1
  } phase_e;

  phase_e                  phase_q, phase_d;
  logic signed [Width-1:0] x_q, y_q, z_q;
  logic signed [Width-1:0] x_d, y_d, z_d;
  logic signed [Width-1:0] dx_q, dy_q, dz_q;
  logic signed [Width-1:0] dx_d, dy_d, dz_d;

  // Full-width signed product, floor-shifted back to Q11.21, wrapped to Width bits.
  function automatic logic signed [Width-1:0] mul(input logic signed [Width-1:0] a,
                                                  input logic signed [Width-1:0] b);
    logic signed [2*Width-1:0] ax;
    logic signed [2*Width-1:0] bx;
    logic signed [2*Width-1:0] p;
    ax = {{Width{a[Width-1]}}, a};
    bx = {{Width{b[Width-1]}}, b};
    p  = ax * bx;
    p  = p >>> FRAC;
    return p[Width-1:0];
  endfunction

  // Phase sequencing; a pause always restarts a full iteration.
  always_comb begin
    phase_d = CALC;
    if (start_i) begin
      case (phase_q)
        CALC:    phase_d = UPDATE;
        UPDATE:  phase_d = CALC;
        default: phase_d = CALC;
      endcase
    end else begin
      phase_d = CALC;
    end
  end

  // Euler increments from the current state, plus the next-state values.
  always_comb begin
    dx_d = mul(HS, y_q - x_q);
    dy_d = mul(H, mul(x_q, RHO - z_q) - y_q);
    dz_d = mul(H, mul(x_q, y_q)) - mul(HB, z_q);
    if (start_i && (phase_q == UPDATE)) begin
      x_d = x_q + dx_q;
      y_d = y_q + dy_q;
      z_d = z_q + dz_q;
    end else begin
      x_d = x_q;
      y_d = y_q;
      z_d = z_q;
    end
  end

  // State, derivative and phase registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= CALC;
      x_q     <= ONE;
      y_q     <= ONE;
      z_q     <= ONE;
      dx_q    <= '0;
      dy_q    <= '0;
      dz_q    <= '0;
    end else begin
      phase_q <= phase_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      if (start_i && (phase_q == CALC)) begin
        dx_q <= dx_d;
        dy_q <= dy_d;
        dz_q <= dz_d;
      end
    end
  end

  assign xn_o = x_q;
  assign yn_o = y_q;
  assign zn_o = z_q;

endmodule

// File: tb/tb_lorenz_attractor.sv
// Self-checking bench for lorenz_attractor: randomized start_i gating checked
// cycle by cycle against an arithmetic model of the Euler recurrence.
module tb_lorenz_attractor;

  localparam int W = 32;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b0;
  logic                start_i = 1'b0;
  logic signed [W-1:0] xn_o, yn_o, zn_o;

  int n_tests = 0;
  int n_fail  = 0;

  longint mx, my, mz;
  int     hi_run;
  int     iters;

  logic signed [W-1:0] xmin, xmax, ymin, ymax, zmin, zmax;

  lorenz_attractor #(.Width(W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .xn_o    (xn_o),
    .yn_o    (yn_o),
    .zn_o    (zn_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic longint wrap32(input longint v);
    logic [31:0] t;
    t = v[31:0];
    return longint'($signed(t));
  endfunction

  function automatic longint fmul(input longint a, input longint b);
    return wrap32((a * b) >>> 21);
  endfunction

  // One Euler step of the Lorenz system at h=0.001 in Q11.21.
  task automatic model_iterate();
    longint dx, dy, dz;
    dx = fmul(20972, wrap32(my - mx));
    dy = fmul(2097, wrap32(fmul(mx, wrap32(64'sh0380_0000 - mz)) - my));
    dz = wrap32(fmul(2097, fmul(mx, my)) - fmul(5592, mz));
    mx = wrap32(mx + dx);
    my = wrap32(my + dy);
    mz = wrap32(mz + dz);
    iters++;
  endtask

  task automatic model_reset();
    mx = 64'sh0020_0000;
    my = 64'sh0020_0000;
    mz = 64'sh0020_0000;
    hi_run = 0;
    iters = 0;
  endtask

  // Drive one clock with the given inputs, advance the model, compare outputs.
  task automatic cyc(input logic s, input logic r);
    start_i = s;
    rst_i   = r;
    @(posedge clk_i);
    #1;
    if (r) begin
      model_reset();
    end else if (s) begin
      hi_run++;
      if (hi_run == 2) begin
        model_iterate();
        hi_run = 0;
      end
    end else begin
      hi_run = 0;
    end
    check("x", xn_o, mx[31:0]);
    check("y", yn_o, my[31:0]);
    check("z", zn_o, mz[31:0]);
    if (xn_o < xmin) xmin = xn_o;
    if (xn_o > xmax) xmax = xn_o;
    if (yn_o < ymin) ymin = yn_o;
    if (yn_o > ymax) ymax = yn_o;
    if (zn_o < zmin) zmin = zn_o;
    if (zn_o > zmax) zmax = zn_o;
  endtask

  task automatic first_step_check(input string pfx);
    logic [W-1:0] x0, y0, z0;
    x0 = xn_o; y0 = yn_o; z0 = zn_o;
    cyc(1'b1, 1'b0);
    check({pfx, "_mid_x"}, xn_o, x0);
    check({pfx, "_mid_y"}, yn_o, y0);
    check({pfx, "_mid_z"}, zn_o, z0);
    cyc(1'b1, 1'b0);
    check({pfx, "_x1"}, xn_o, 32'h0020_0000);
    check({pfx, "_y1"}, yn_o, 32'h0020_D4FA);
    check({pfx, "_z1"}, zn_o, 32'h001F_F259);
  endtask

  initial begin
    model_reset();
    xmin = 32'sh7FFF_FFFF; xmax = 32'sh8000_0000;
    ymin = 32'sh7FFF_FFFF; ymax = 32'sh8000_0000;
    zmin = 32'sh7FFF_FFFF; zmax = 32'sh8000_0000;

    cyc(1'b0, 1'b1);
    check("rst_x", xn_o, 32'h0020_0000);
    check("rst_y", yn_o, 32'h0020_0000);
    check("rst_z", zn_o, 32'h0020_0000);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
    check("hold_z", zn_o, 32'h0020_0000);

    first_step_check("step");

    // Randomized gating with occasional 10-cycle pauses, up to 1000 iterations.
    while (iters < 1000) begin
      if ($urandom_range(0, 19) == 0) begin
        logic [W-1:0] px;
        px = yn_o;
        for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0);
        check("pause_y", yn_o, px);
        cyc(1'b1, 1'b0);
        check("resume_mid_y", yn_o, px);
        cyc(1'b1, 1'b0);
      end else begin
        cyc($urandom_range(0, 7) != 0, 1'b0);
      end
    end

    // Reset mid-iteration with start held high: reset wins.
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    check("midrst_x", xn_o, 32'h0020_0000);
    check("midrst_y", yn_o, 32'h0020_0000);
    check("midrst_z", zn_o, 32'h0020_0000);
    cyc(1'b0, 1'b0);
    first_step_check("replay");

    xmin = 32'sh7FFF_FFFF; xmax = 32'sh8000_0000;
    ymin = 32'sh7FFF_FFFF; ymax = 32'sh8000_0000;
    zmin = 32'sh7FFF_FFFF; zmax = 32'sh8000_0000;
    while (iters < 20000) cyc($urandom_range(0, 31) != 0, 1'b0);

    check("range_x", {31'd0, (xmin > -32'sd52428800) && (xmax < 32'sd52428800)}, 32'd1);
    check("range_y", {31'd0, (ymin > -32'sd67108864) && (ymax < 32'sd67108864)}, 32'd1);
    check("range_z", {31'd0, (zmin > -32'sd2097152) && (zmax < 32'sd115343360)}, 32'd1);
    check("two_lobes", {31'd0, (xmin < -32'sd10485760) && (xmax > 32'sd10485760)}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
